// File: rtl/belfft_pkg.sv
// Shared definitions for the bel_fft core: default sizes, twiddle-fetch FSM states
// and the field layout of a twiddle ROM word ({real, imag}).
package belfft_pkg;

    localparam int LOG2N_DEFAULT = 7;
    localparam int TW_DW         = 32;

    // Imag part sits in the low half of the ROM word, real part directly above it
    localparam int TW_IM_LSB = 0;
    localparam int TW_RE_LSB = TW_DW;

    typedef enum logic [1:0] {
        TWF_IDLE  = 2'd0,
        TWF_RUN   = 2'd1,
        TWF_DRAIN = 2'd2
    } twf_state_e;

endpackage

// File: rtl/belfft_skid_fifo2.sv
// Two-entry registered FIFO with a stable head; used to absorb the one-cycle ROM
// latency so a stalled consumer never loses or duplicates a word.
module belfft_skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/belfft_twiddle_fetch.sv
// Twiddle-factor fetch sequencer: walks the 64 butterflies of one radix-2 stage,
// reads the twiddle ROM and streams {b, re, im} out over valid/ready.
module belfft_twiddle_fetch
    import belfft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEFAULT,
    parameter int DW    = TW_DW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       stage,
    input  logic             inverse,
    output logic             busy,
    output logic             done,
    output logic             rom_clken,
    output logic [LOG2N-1:0] rom_address,
    input  logic [2*DW-1:0]  rom_q,
    output logic             tw_valid,
    input  logic             tw_ready,
    output logic [DW-1:0]    tw_re,
    output logic [DW-1:0]    tw_im,
    output logic [LOG2N-2:0] tw_index
);

    localparam int BW     = LOG2N - 1;
    localparam int FW     = BW + 2*DW;
    localparam int RE_LSB = TW_IM_LSB + DW;

    twf_state_e       state;
    twf_state_e       state_nxt;
    logic [2:0]       stage_clamped;
    logic [2:0]       stage_q;
    logic             inv_q;
    logic [BW-1:0]    b_cnt;
    logic [LOG2N-1:0] addr_nxt;
    logic [LOG2N-1:0] addr_q;
    logic             issue;
    logic             done_nxt;
    logic             pop;
    logic [2:0]       occ;
    logic             vld_p1;
    logic [BW-1:0]    b_p1;
    logic [1:0]       fifo_count;
    logic [FW-1:0]    fifo_head;

    // Exponent k of W_N^k for butterfly b at stage s; inverse uses (-k) mod N
    function automatic logic [LOG2N-1:0] tw_addr(input logic [BW-1:0] b,
                                                 input logic [2:0]    s,
                                                 input logic          inv);
        logic [LOG2N-1:0] mask;
        logic [LOG2N-1:0] a;
        mask = LOG2N'((1 << s) - 1);
        a    = (LOG2N'(b) & mask) << (BW - int'(s));
        if (inv) begin
            a = -a;
        end
        return a;
    endfunction

    assign stage_clamped = (stage >= 3'(LOG2N - 1)) ? 3'(LOG2N - 1) : stage;
    assign addr_nxt      = tw_addr(b_cnt, stage_q, inv_q);
    assign pop           = tw_valid && tw_ready;
    assign occ           = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, pop};

    assign busy        = (state != TWF_IDLE);
    assign rom_clken   = issue;
    assign rom_address = issue ? addr_nxt : addr_q;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            TWF_IDLE: begin
                if (start) begin
                    state_nxt = TWF_RUN;
                end
            end
            TWF_RUN: begin
                issue = (occ < 3'd2);
                if (issue && (b_cnt == '1)) begin
                    state_nxt = TWF_DRAIN;
                end
            end
            TWF_DRAIN: begin
                // Last word leaves the buffer this cycle (or already has)
                if (!vld_p1 && (fifo_count == {1'b0, pop})) begin
                    state_nxt = TWF_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = TWF_IDLE;
        endcase
    end

    // p0 -> p1: issue stage, ROM read in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= TWF_IDLE;
            done    <= 1'b0;
            stage_q <= 3'd0;
            inv_q   <= 1'b0;
            b_cnt   <= '0;
            addr_q  <= '0;
            vld_p1  <= 1'b0;
            b_p1    <= '0;
        end else begin
            state  <= state_nxt;
            done   <= done_nxt;
            vld_p1 <= issue;
            if ((state == TWF_IDLE) && start) begin
                stage_q <= stage_clamped;
                inv_q   <= inverse;
                b_cnt   <= '0;
            end else if (issue) begin
                b_cnt  <= b_cnt + 1'b1;
                b_p1   <= b_cnt;
                addr_q <= addr_nxt;
            end
        end
    end

    // p1 -> p2: ROM data tagged with its butterfly index enters the output buffer
    belfft_skid_fifo2 #(
        .W (FW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (vld_p1),
        .push_data ({b_p1, rom_q}),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign tw_valid = (fifo_count != 2'd0);
    assign tw_index = fifo_head[2*DW +: BW];
    assign tw_re    = fifo_head[RE_LSB +: DW];
    assign tw_im    = fifo_head[TW_IM_LSB +: DW];

endmodule

// File: tb/tb_belfft_twiddle_fetch.sv
// Directed bench for belfft_twiddle_fetch with an arithmetic twiddle-address model
// and a ROM whose contents are unique per address.
module tb_belfft_twiddle_fetch;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  stage;
    logic        inverse;
    logic        busy;
    logic        done;
    logic        rom_clken;
    logic [6:0]  rom_address;
    logic [63:0] rom_q;
    logic        tw_valid;
    logic        tw_ready;
    logic [31:0] tw_re;
    logic [31:0] tw_im;
    logic [5:0]  tw_index;

    belfft_twiddle_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stage       (stage),
        .inverse     (inverse),
        .busy        (busy),
        .done        (done),
        .rom_clken   (rom_clken),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .tw_valid    (tw_valid),
        .tw_ready    (tw_ready),
        .tw_re       (tw_re),
        .tw_im       (tw_im),
        .tw_index    (tw_index)
    );

    int checks   = 0;
    int failures = 0;

    logic [63:0] rom_mem [128];
    logic [6:0]  exp_addr [64];
    logic [6:0]  got_addr [64];
    logic [31:0] got_re [64];
    logic [31:0] got_im [64];

    int   cyc = 0;
    int   start_cyc = 0;
    int   rel;
    bit   active = 0;
    bit   timing_chk = 0;
    bit   rand_ready = 0;
    int   issue_n, out_n, done_cnt;
    int   first_issue, last_issue, first_out, last_out, done_rel;
    bit   done_seen;
    bit   prev_stall;
    logic [69:0] prev_word;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (rom_clken) rom_q <= rom_mem[rom_address];
    end

    always @(posedge clock) begin
        #1;
        if (rand_ready) tw_ready = ($urandom_range(0, 99) >= 30);
        else            tw_ready = 1'b1;
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (active) begin
            rel = cyc - start_cyc;
            chk("fifo_count_le2", 72'(dut.u_fifo.count <= 2'd2), 72'(1));
            if (timing_chk) chk("busy", 72'(busy), 72'(rel >= 1 && rel <= 66));
            if (rom_clken) begin
                chk("issue_within_64", 72'(issue_n < 64), 72'(1));
                if (issue_n < 64) begin
                    chk("rom_address", 72'(rom_address), 72'(exp_addr[issue_n]));
                    got_addr[issue_n] = rom_address;
                end
                if (issue_n == 0) first_issue = rel;
                last_issue = rel;
                issue_n++;
            end
            if (prev_stall) begin
                chk("hold_valid", 72'(tw_valid), 72'(1));
                chk("hold_data", 72'({tw_index, tw_re, tw_im}), 72'(prev_word));
            end
            if (tw_valid && tw_ready) begin
                chk("out_within_64", 72'(out_n < 64), 72'(1));
                if (out_n < 64) begin
                    chk("tw_index", 72'(tw_index), 72'(out_n));
                    chk("tw_word", 72'({tw_re, tw_im}), 72'(rom_mem[exp_addr[out_n]]));
                    got_re[out_n] = tw_re;
                    got_im[out_n] = tw_im;
                end
                if (out_n == 0) first_out = rel;
                last_out = rel;
                out_n++;
            end
            prev_stall = tw_valid && !tw_ready;
            prev_word  = {tw_index, tw_re, tw_im};
            if (done) begin
                done_cnt++;
                done_rel  = rel;
                done_seen = 1'b1;
            end
        end
    end

    task automatic setup_model(input int s, input logic inv);
        int ms;
        int a;
        ms = (s > 6) ? 6 : s;
        for (int b = 0; b < 64; b++) begin
            a = (b % (1 << ms)) * (1 << (6 - ms));
            if (inv) a = (128 - a) % 128;
            exp_addr[b] = 7'(a);
        end
        issue_n = 0; out_n = 0; done_cnt = 0; done_seen = 1'b0; prev_stall = 1'b0;
        first_issue = -1; last_issue = -1; first_out = -1; last_out = -1; done_rel = -1;
    endtask

    task automatic run_stage(input int s, input logic inv, input bit rnd, input bit tim, input bit poke);
        setup_model(s, inv);
        timing_chk = tim;
        rand_ready = rnd;
        @(negedge clock);
        stage = 3'(s); inverse = inv; start = 1'b1; start_cyc = cyc; active = 1'b1;
        @(negedge clock);
        start = 1'b0;
        if (poke) begin
            repeat (8) @(negedge clock);
            stage = 3'd0; inverse = ~inv; start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        for (int i = 0; i < 2000 && !done_seen; i++) begin
            @(negedge clock); #1;
        end
        chk("done_seen", 72'(done_seen), 72'(1));
        rand_ready = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("issue_count", 72'(issue_n), 72'(64));
        chk("out_count", 72'(out_n), 72'(64));
        chk("done_count", 72'(done_cnt), 72'(1));
        if (tim) begin
            chk("first_issue_cycle", 72'(first_issue), 72'(1));
            chk("last_issue_cycle", 72'(last_issue), 72'(64));
            chk("first_out_cycle", 72'(first_out), 72'(3));
            chk("last_out_cycle", 72'(last_out), 72'(66));
            chk("done_cycle", 72'(done_rel), 72'(67));
        end
        active = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 128; a++)
            rom_mem[a] = {32'(32'h13570000 + a * 257), 32'(32'hC0DE0000 + a * 3)};
        rom_mem[0]     = {32'h7FFFFFFF, 32'h00000000};
        rom_mem[1]     = {32'h7FD8878D, 32'hF9B82684};
        rom_mem[2]     = {32'h7F62368E, 32'hF3742CA2};
        rom_mem[7'h20] = {32'h00000000, 32'h80000001};
        rom_mem[7'h7F] = {32'h7FD8878D, 32'h0647D97C};
        rom_q = '0;
        tw_ready = 1'b1;
        reset = 1'b1; start = 1'b0; stage = 3'd0; inverse = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_outputs", 72'({busy, done, rom_clken, rom_address, tw_valid, tw_re, tw_im, tw_index}), 72'(0));
        reset = 1'b0;

        run_stage(6, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("s6_b1_addr", 72'(got_addr[1]), 72'(7'd1));
        chk("s6_b1_word", 72'({got_re[1], got_im[1]}), 72'(64'h7FD8878D_F9B82684));
        chk("s6_b32_addr", 72'(got_addr[32]), 72'(7'h20));
        chk("s6_b32_word", 72'({got_re[32], got_im[32]}), 72'(64'h00000000_80000001));
        chk("idle_addr_hold", 72'(rom_address), 72'(7'd63));
        chk("idle_clken", 72'(rom_clken), 72'(0));

        run_stage(0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("s0_b63_addr", 72'(got_addr[63]), 72'(0));
        chk("s0_b40_word", 72'({got_re[40], got_im[40]}), 72'(64'h7FFFFFFF_00000000));

        run_stage(5, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("s5_b1_addr", 72'(got_addr[1]), 72'(7'd2));
        chk("s5_b1_word", 72'({got_re[1], got_im[1]}), 72'(64'h7F62368E_F3742CA2));
        chk("s5_b33_addr", 72'(got_addr[33]), 72'(7'd2));

        run_stage(6, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("inv_b1_addr", 72'(got_addr[1]), 72'(7'h7F));
        chk("inv_b1_word", 72'({got_re[1], got_im[1]}), 72'(64'h7FD8878D_0647D97C));
        chk("inv_b0_addr", 72'(got_addr[0]), 72'(0));

        run_stage(7, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("s7_b1_addr", 72'(got_addr[1]), 72'(7'd1));
        chk("s7_b63_addr", 72'(got_addr[63]), 72'(7'd63));

        run_stage(6, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a stage, at the cycle butterfly 20 is issued
        setup_model(6, 1'b0);
        timing_chk = 1'b0;
        @(negedge clock);
        stage = 3'd6; inverse = 1'b0; start = 1'b1; start_cyc = cyc; active = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 200 && issue_n < 21; i++) begin
            @(negedge clock); #1;
        end
        chk("reached_b20", 72'(issue_n), 72'(21));
        active = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_outputs", 72'({busy, done, rom_clken, rom_address, tw_valid, tw_re, tw_im, tw_index}), 72'(0));
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("no_done_after_rst", 72'({done, busy, tw_valid}), 72'(0));
        run_stage(6, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
